// File: rtl/mips_cpu_muldiv_if.sv
// Handshake and operand/result bus between the CPU pipeline and the
// iterative multiply/divide unit.
interface mips_cpu_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output start, op, a, b,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi_out, lo_out
  );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS multiply/divide unit: 32-step shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up on the final edge.
module mips_cpu_muldiv (
  input  logic              clk,
  input  logic              rst,
  mips_cpu_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  op_r;
  logic [31:0] a_r, b_r;
  logic [63:0] acc, acc_step;
  logic [31:0] opnd;
  logic [4:0]  cnt;
  logic [31:0] hi_r, lo_r;
  logic [31:0] res_hi, res_lo;
  logic [31:0] mag_a, mag_b;
  logic        last_iter;

  logic        in_signed;
  logic        run_signed;
  logic [32:0] mul_sum;
  logic [32:0] div_tmp, div_diff;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  assign last_iter  = (cnt == 5'd31);
  assign in_signed  = ~bus.op[0];
  assign run_signed = ~op_r[0];
  assign mag_a      = (in_signed && bus.a[31]) ? -bus.a : bus.a;
  assign mag_b      = (in_signed && bus.b[31]) ? -bus.b : bus.b;

  assign bus.hi_out = hi_r;
  assign bus.lo_out = lo_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: if (bus.start) state_next = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    div_tmp  = {acc[63:32], acc[31]};
    div_diff = div_tmp - {1'b0, opnd};
    acc_step = acc;
    if (!op_r[1]) begin
      acc_step = {mul_sum, acc[31:1]};
    end else if (!div_diff[32]) begin
      acc_step = {div_diff[31:0], acc[30:0], 1'b1};
    end else begin
      acc_step = {div_tmp[31:0], acc[30:0], 1'b0};
    end
  end

  always_comb begin
    prod   = (run_signed && (a_r[31] ^ b_r[31])) ? -acc_step : acc_step;
    quo    = acc_step[31:0];
    rem    = acc_step[63:32];
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (op_r[1]) begin
      if (b_r == 32'd0) begin
        res_hi = a_r;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_lo = (run_signed && (a_r[31] ^ b_r[31])) ? -quo : quo;
        res_hi = (run_signed && a_r[31]) ? -rem : rem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r <= 2'd0;
      a_r  <= 32'd0;
      b_r  <= 32'd0;
      acc  <= 64'd0;
      opnd <= 32'd0;
      cnt  <= 5'd0;
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r <= bus.op;
            a_r  <= bus.a;
            b_r  <= bus.b;
            cnt  <= 5'd0;
            if (bus.op[1]) begin
              acc  <= {32'd0, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {32'd0, mag_b};
              opnd <= mag_a;
            end
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 5'd1;
          if (last_iter) begin
            hi_r <= res_hi;
            lo_r <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed corner cases, a mid-run
// reset scenario and randomized operations against an arithmetic model.
module tb_mips_cpu_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] prev_hi = 32'd0;
  logic [31:0] prev_lo = 32'd0;

  mips_cpu_muldiv_if bus();

  mips_cpu_muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain MIPS arithmetic, returns {hi, lo}.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sq, sr;
    case (op)
      2'd0: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {sr, sq};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Runs one operation, scrambling inputs after E0 and toggling start during RUN.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp);
    int edges;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.a     = $urandom;
    bus.b     = $urandom;
    checkOutput("busy_after_start", {63'd0, bus.busy}, 64'd1);
    edges = 0;
    while (!bus.done && edges < 40) begin
      if (edges == 10)
        checkOutput("hold_prev_result", {bus.hi_out, bus.lo_out}, {prev_hi, prev_lo});
      bus.start = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      edges++;
    end
    bus.start = 1'b0;
    checkOutput("latency_edges", 64'(edges), 64'd32);
    checkOutput("hi_lo", {bus.hi_out, bus.lo_out}, exp);
    prev_hi = exp[63:32];
    prev_lo = exp[31:0];
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", {62'd0, bus.busy, bus.done}, 64'd0);
    checkOutput("hold_in_idle", {bus.hi_out, bus.lo_out}, exp);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          seen_done;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;

    // Reset, with start asserted to confirm reset wins.
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_state", {bus.busy, bus.done, bus.hi_out, bus.lo_out}, 66'd0);
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;

    applyStimulus(2'd0, 32'hFFFF_FFFD, 32'd5,          {32'hFFFF_FFFF, 32'hFFFF_FFF1});
    applyStimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  {32'hFFFF_FFFE, 32'h0000_0001});
    applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    applyStimulus(2'd3, 32'd100,       32'd0,          {32'h0000_0064, 32'hFFFF_FFFF});
    applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  {32'h0000_0000, 32'h8000_0000});

    // DIVU 100/7, extra start with new operands mid-RUN, then reset at RUN cycle 10.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd3;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (i == 3) begin
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("busy_before_rst", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrun_reset", {bus.busy, bus.done, bus.hi_out, bus.lo_out}, 66'd0);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen_done++;
    end
    checkOutput("no_done_after_rst", 64'(seen_done), 64'd0);
    prev_hi = 32'd0;
    prev_lo = 32'd0;

    // Start on the very first edge after reset is released.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(2'd1, 32'd6, 32'd7, {32'd0, 32'd42});

    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        2:       ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      applyStimulus(rop, ra, rb, ref_model(rop, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
